// File: rtl/mem_arb_ctrl_if.sv
// mem_arb_ctrl_if: fetch/LSU request buses and banked-memory port bundle for mem_arb_ctrl.
interface mem_arb_ctrl_if;
  logic        i_if_req;
  logic [10:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_ls_req;
  logic        i_ls_we;
  logic [1:0]  i_ls_size;
  logic        i_ls_unsigned;
  logic [10:0] i_ls_addr;
  logic [31:0] i_ls_wdata;
  logic        o_ls_gnt;
  logic        o_ls_rvalid;
  logic [31:0] o_ls_rdata;
  logic [9:0]  o_addr_even_1, o_addr_even_2, o_addr_odd_1, o_addr_odd_2;
  logic [7:0]  o_data_even_1, o_data_even_2, o_data_odd_1, o_data_odd_2;
  logic        o_we_even_1, o_we_even_2, o_we_odd_1, o_we_odd_2;
  logic        o_lsu_addr;
  logic [31:0] i_mem_data;
  modport slave (
    input  i_if_req, i_if_addr, i_ls_req, i_ls_we, i_ls_size, i_ls_unsigned, i_ls_addr, i_ls_wdata, i_mem_data,
    output o_if_gnt, o_if_rvalid, o_if_rdata, o_ls_gnt, o_ls_rvalid, o_ls_rdata,
           o_addr_even_1, o_addr_even_2, o_addr_odd_1, o_addr_odd_2,
           o_data_even_1, o_data_even_2, o_data_odd_1, o_data_odd_2,
           o_we_even_1, o_we_even_2, o_we_odd_1, o_we_odd_2, o_lsu_addr
  );
  modport master (
    output i_if_req, i_if_addr, i_ls_req, i_ls_we, i_ls_size, i_ls_unsigned, i_ls_addr, i_ls_wdata, i_mem_data,
    input  o_if_gnt, o_if_rvalid, o_if_rdata, o_ls_gnt, o_ls_rvalid, o_ls_rdata,
           o_addr_even_1, o_addr_even_2, o_addr_odd_1, o_addr_odd_2,
           o_data_even_1, o_data_even_2, o_data_odd_1, o_data_odd_2,
           o_we_even_1, o_we_even_2, o_we_odd_1, o_we_odd_2, o_lsu_addr
  );
endinterface

// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl: fetch/LSU arbiter driving an even/odd byte-banked memory with one-cycle read return.
module mem_arb_ctrl #(
  parameter int LS_BURST_MAX = 2
) (
  input logic           i_clk,
  input logic           i_reset,
  mem_arb_ctrl_if.slave bus
);
  localparam int CW = $clog2(LS_BURST_MAX + 1);
  logic [CW-1:0] cnt;
  logic          r_if_v, r_ls_v, r_a0, r_uns;
  logic [1:0]    r_size;
  logic          if_win, ls_win, gnt, odd, st, sgn;
  logic [10:0]   addr;
  logic [9:0]    a, a1, a2;
  logic [3:0]    we_l;
  logic [31:0]   wd, ext;
  always_comb begin
    if_win = !i_reset && bus.i_if_req && (!bus.i_ls_req || cnt == CW'(LS_BURST_MAX));
    ls_win = !i_reset && bus.i_ls_req && !if_win;
    gnt    = if_win || ls_win;
    addr   = if_win ? bus.i_if_addr : bus.i_ls_addr;
    odd    = gnt && addr[0];
    a      = addr[10:1];
    a1     = a + 10'd1;
    a2     = a + 10'd2;
    st     = ls_win && bus.i_ls_we;
    we_l   = !st ? 4'h0 : bus.i_ls_size[1] ? 4'hf : bus.i_ls_size[0] ? 4'h3 : 4'h1;
    wd     = st ? bus.i_ls_wdata : 32'h0;
    sgn    = !r_uns && !r_size[1] && (r_size[0] ? bus.i_mem_data[15] : bus.i_mem_data[7]);
    ext    = r_size[1] ? bus.i_mem_data :
             r_size[0] ? {{16{sgn}}, bus.i_mem_data[15:0]} : {{24{sgn}}, bus.i_mem_data[7:0]};
  end
  // Lane k is byte k of the access; an odd start address swaps the even/odd bank roles.
  assign bus.o_if_gnt      = if_win;
  assign bus.o_ls_gnt      = ls_win;
  assign bus.o_addr_odd_1  = gnt ? a : 10'd0;
  assign bus.o_addr_even_1 = gnt ? (odd ? a1 : a) : 10'd0;
  assign bus.o_addr_odd_2  = gnt ? a1 : 10'd0;
  assign bus.o_addr_even_2 = gnt ? (odd ? a2 : a1) : 10'd0;
  assign bus.o_we_even_1   = odd ? we_l[1] : we_l[0];
  assign bus.o_we_odd_1    = odd ? we_l[0] : we_l[1];
  assign bus.o_we_even_2   = odd ? we_l[3] : we_l[2];
  assign bus.o_we_odd_2    = odd ? we_l[2] : we_l[3];
  assign bus.o_data_even_1 = odd ? wd[15:8] : wd[7:0];
  assign bus.o_data_odd_1  = odd ? wd[7:0] : wd[15:8];
  assign bus.o_data_even_2 = odd ? wd[31:24] : wd[23:16];
  assign bus.o_data_odd_2  = odd ? wd[23:16] : wd[31:24];
  assign bus.o_lsu_addr    = r_a0 && !i_reset;
  assign bus.o_if_rvalid   = r_if_v && !i_reset;
  assign bus.o_ls_rvalid   = r_ls_v && !i_reset;
  assign bus.o_if_rdata    = bus.o_if_rvalid ? bus.i_mem_data : 32'h0;
  assign bus.o_ls_rdata    = bus.o_ls_rvalid ? ext : 32'h0;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt    <= '0;
      r_if_v <= 1'b0;
      r_ls_v <= 1'b0;
      r_a0   <= 1'b0;
      r_size <= 2'b00;
      r_uns  <= 1'b0;
    end else begin
      cnt    <= (!bus.i_if_req || if_win) ? '0 : (ls_win && cnt != CW'(LS_BURST_MAX)) ? cnt + CW'(1) : cnt;
      r_if_v <= if_win;
      r_ls_v <= ls_win && !bus.i_ls_we;
      r_a0   <= odd;
      r_size <= bus.i_ls_size;
      r_uns  <= bus.i_ls_unsigned;
    end
  end
endmodule

// File: tb/tb_mem_arb_ctrl.sv
// tb_mem_arb_ctrl: vector table with a read-return scoreboard plus reset/arbitration sequences.
module tb_mem_arb_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_arb_ctrl_if bus();
  mem_arb_ctrl #(.LS_BURST_MAX(2)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));
  typedef struct {
    logic        ifr;
    logic [10:0] ifa;
    logic        lsr, we;
    logic [1:0]  sz;
    logic        un;
    logic [10:0] lsa;
    logic [31:0] wd, mem;
    logic [1:0]  gnt;
    logic [39:0] addr;
    logic [3:0]  wem;
    logic [31:0] dat;
    logic [1:0]  rv;
    logic [31:0] rd;
    logic        a0;
  } vec_t;
  typedef struct {
    logic [1:0]  rv;
    logic [31:0] rd;
    logic        a0, chk_a0;
    logic [31:0] mem;
  } exp_t;
  vec_t tbl[24];
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [1:0]   gnt_o, rv_o;
  logic [39:0]  addr_o;
  logic [31:0]  dat_o;
  logic [3:0]   we_o;
  logic [63:0]  rd_o;
  logic [144:0] all_o;
  assign gnt_o  = {bus.o_if_gnt, bus.o_ls_gnt};
  assign rv_o   = {bus.o_if_rvalid, bus.o_ls_rvalid};
  assign addr_o = {bus.o_addr_even_1, bus.o_addr_odd_1, bus.o_addr_even_2, bus.o_addr_odd_2};
  assign dat_o  = {bus.o_data_even_1, bus.o_data_odd_1, bus.o_data_even_2, bus.o_data_odd_2};
  assign we_o   = {bus.o_we_even_1, bus.o_we_odd_1, bus.o_we_even_2, bus.o_we_odd_2};
  assign rd_o   = {bus.o_if_rdata, bus.o_ls_rdata};
  assign all_o  = {gnt_o, rv_o, bus.o_lsu_addr, addr_o, dat_o, we_o, rd_o};
  function automatic vec_t mk(logic ifr, logic [10:0] ifa, logic lsr, logic we, logic [1:0] sz, logic un,
                              logic [10:0] lsa, logic [31:0] wd, logic [31:0] mem, logic [1:0] gnt,
                              logic [39:0] addr, logic [3:0] wem, logic [31:0] dat, logic [1:0] rv,
                              logic [31:0] rd, logic a0);
    vec_t v;
    v.ifr = ifr; v.ifa = ifa; v.lsr = lsr; v.we = we; v.sz = sz; v.un = un; v.lsa = lsa; v.wd = wd;
    v.mem = mem; v.gnt = gnt; v.addr = addr; v.wem = wem; v.dat = dat; v.rv = rv; v.rd = rd; v.a0 = a0;
    return v;
  endfunction
  task automatic chk(input string nm, input int idx, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask
  task automatic drive(input logic ifr, input logic [10:0] ifa, input logic lsr, input logic we,
                       input logic [1:0] sz, input logic un, input logic [10:0] lsa, input logic [31:0] wd);
    bus.i_if_req = ifr; bus.i_if_addr = ifa; bus.i_ls_req = lsr; bus.i_ls_we = we;
    bus.i_ls_size = sz; bus.i_ls_unsigned = un; bus.i_ls_addr = lsa; bus.i_ls_wdata = wd;
  endtask
  task automatic run(input vec_t v, input int idx);
    exp_t e;
    @(posedge clk); #1;
    drive(v.ifr, v.ifa, v.lsr, v.we, v.sz, v.un, v.lsa, v.wd);
    bus.i_mem_data = (q.size() > 0) ? q[0].mem : 32'h0;
    @(negedge clk);
    chk("gnt", idx, 160'(gnt_o), 160'(v.gnt));
    chk("bank_addr", idx, 160'(addr_o), 160'(v.addr));
    chk("bank_we", idx, 160'(we_o), 160'(v.wem));
    chk("bank_data", idx, 160'(dat_o), 160'(v.dat));
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rvalid", idx, 160'(rv_o), 160'(e.rv));
      chk("rdata", idx, 160'(rd_o), 160'(e.rv[1] ? {e.rd, 32'h0} : e.rv[0] ? {32'h0, e.rd} : 64'h0));
      if (e.chk_a0) chk("lsu_addr", idx, 160'(bus.o_lsu_addr), 160'(e.a0));
    end else chk("rvalid_idle", idx, 160'(rv_o), 160'(2'b00));
    e.rv = v.rv; e.rd = v.rd; e.a0 = v.a0; e.chk_a0 = |v.gnt; e.mem = v.mem;
    q.push_back(e);
  endtask
  task automatic step_gnt(input logic ifr, input logic lsr, input logic [1:0] g, input int idx);
    @(posedge clk); #1;
    drive(ifr, 11'h010, lsr, 1'b0, 2'b10, 1'b0, 11'h004, 32'h0);
    @(negedge clk);
    chk("seq_gnt", idx, 160'(gnt_o), 160'(g));
  endtask
  initial begin
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 40'd0, 4'b0000, 32'h0, 2'b00, 32'h0, 0);
    tbl[1]  = mk(0, 0, 1, 1, 2'b10, 0, 11'h005, 32'hDDCCBBAA, 0, 2'b01, {10'd3, 10'd2, 10'd4, 10'd3}, 4'b1111, 32'hBBAADDCC, 2'b00, 32'h0, 1);
    tbl[2]  = mk(0, 0, 1, 1, 2'b00, 0, 11'h006, 32'h11223344, 0, 2'b01, {10'd3, 10'd3, 10'd4, 10'd4}, 4'b1000, 32'h44332211, 2'b00, 32'h0, 0);
    tbl[3]  = mk(0, 0, 1, 0, 2'b00, 0, 11'h005, 0, 32'h000000F0, 2'b01, {10'd3, 10'd2, 10'd4, 10'd3}, 4'b0000, 32'h0, 2'b01, 32'hFFFFFFF0, 1);
    tbl[4]  = mk(0, 0, 1, 0, 2'b00, 1, 11'h005, 0, 32'h000000F0, 2'b01, {10'd3, 10'd2, 10'd4, 10'd3}, 4'b0000, 32'h0, 2'b01, 32'h000000F0, 1);
    tbl[5]  = mk(0, 0, 1, 0, 2'b10, 0, 11'h7FF, 0, 32'h12345678, 2'b01, {10'd0, 10'd1023, 10'd1, 10'd0}, 4'b0000, 32'h0, 2'b01, 32'h12345678, 1);
    tbl[6]  = mk(1, 11'h010, 0, 0, 0, 0, 0, 0, 32'hCAFEBABE, 2'b10, {10'd8, 10'd8, 10'd9, 10'd9}, 4'b0000, 32'h0, 2'b10, 32'hCAFEBABE, 0);
    tbl[7]  = mk(0, 0, 1, 0, 2'b01, 0, 11'h002, 0, 32'h00018765, 2'b01, {10'd1, 10'd1, 10'd2, 10'd2}, 4'b0000, 32'h0, 2'b01, 32'hFFFF8765, 0);
    tbl[8]  = mk(0, 0, 1, 0, 2'b01, 1, 11'h002, 0, 32'hFFFF8765, 2'b01, {10'd1, 10'd1, 10'd2, 10'd2}, 4'b0000, 32'h0, 2'b01, 32'h00008765, 0);
    tbl[9]  = mk(0, 0, 1, 1, 2'b01, 0, 11'h003, 32'hAABBCCDD, 0, 2'b01, {10'd2, 10'd1, 10'd3, 10'd2}, 4'b1100, 32'hCCDDAABB, 2'b00, 32'h0, 1);
    tbl[10] = mk(1, 11'h7FF, 0, 0, 0, 0, 0, 0, 32'h0BADF00D, 2'b10, {10'd0, 10'd1023, 10'd1, 10'd0}, 4'b0000, 32'h0, 2'b10, 32'h0BADF00D, 1);
    tbl[11] = mk(1, 11'h008, 1, 0, 2'b10, 0, 11'h004, 0, 32'h11111111, 2'b01, {10'd2, 10'd2, 10'd3, 10'd3}, 4'b0000, 32'h0, 2'b01, 32'h11111111, 0);
    tbl[12] = mk(1, 11'h008, 1, 0, 2'b10, 0, 11'h004, 0, 32'h22222222, 2'b01, {10'd2, 10'd2, 10'd3, 10'd3}, 4'b0000, 32'h0, 2'b01, 32'h22222222, 0);
    tbl[13] = mk(1, 11'h008, 1, 0, 2'b10, 0, 11'h004, 0, 32'h33333333, 2'b10, {10'd4, 10'd4, 10'd5, 10'd5}, 4'b0000, 32'h0, 2'b10, 32'h33333333, 0);
    tbl[14] = mk(1, 11'h008, 1, 0, 2'b10, 0, 11'h004, 0, 32'h44444444, 2'b01, {10'd2, 10'd2, 10'd3, 10'd3}, 4'b0000, 32'h0, 2'b01, 32'h44444444, 0);
    tbl[15] = mk(1, 11'h008, 1, 0, 2'b10, 0, 11'h004, 0, 32'h55555555, 2'b01, {10'd2, 10'd2, 10'd3, 10'd3}, 4'b0000, 32'h0, 2'b01, 32'h55555555, 0);
    tbl[16] = mk(1, 11'h008, 1, 0, 2'b10, 0, 11'h004, 0, 32'h66666666, 2'b10, {10'd4, 10'd4, 10'd5, 10'd5}, 4'b0000, 32'h0, 2'b10, 32'h66666666, 0);
    tbl[17] = mk(1, 11'h008, 1, 0, 2'b10, 0, 11'h004, 0, 32'h77777777, 2'b01, {10'd2, 10'd2, 10'd3, 10'd3}, 4'b0000, 32'h0, 2'b01, 32'h77777777, 0);
    tbl[18] = mk(0, 11'h008, 1, 0, 2'b10, 0, 11'h004, 0, 32'h88888888, 2'b01, {10'd2, 10'd2, 10'd3, 10'd3}, 4'b0000, 32'h0, 2'b01, 32'h88888888, 0);
    tbl[19] = mk(1, 11'h008, 1, 0, 2'b10, 0, 11'h004, 0, 32'h99999999, 2'b01, {10'd2, 10'd2, 10'd3, 10'd3}, 4'b0000, 32'h0, 2'b01, 32'h99999999, 0);
    tbl[20] = mk(1, 11'h008, 1, 0, 2'b10, 0, 11'h004, 0, 32'hAAAAAAAA, 2'b01, {10'd2, 10'd2, 10'd3, 10'd3}, 4'b0000, 32'h0, 2'b01, 32'hAAAAAAAA, 0);
    tbl[21] = mk(1, 11'h008, 1, 0, 2'b10, 0, 11'h004, 0, 32'hBBBBBBBB, 2'b10, {10'd4, 10'd4, 10'd5, 10'd5}, 4'b0000, 32'h0, 2'b10, 32'hBBBBBBBB, 0);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 40'd0, 4'b0000, 32'h0, 2'b00, 32'h0, 0);
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 40'd0, 4'b0000, 32'h0, 2'b00, 32'h0, 0);
    drive(1, 11'h7FF, 1, 1, 2'b10, 0, 11'h7FF, 32'hFFFFFFFF);
    bus.i_mem_data = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outputs", i, 160'(all_o), 160'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    bus.i_mem_data = 32'h0;
    for (int i = 0; i < 24; i++) run(tbl[i], i);
    q.delete();
    step_gnt(1, 0, 2'b10, 100);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.i_mem_data = 32'hFFFFFFFF;
    @(negedge clk);
    chk("reset_inflight", 101, 160'(all_o), 160'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_hold", 102, 160'(all_o), 160'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_reset_rvalid", 103, 160'(rv_o), 160'd0);
    step_gnt(1, 1, 2'b01, 104);
    step_gnt(1, 1, 2'b01, 105);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("reset_gnt", 106, 160'(gnt_o), 160'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_gnt", 107, 160'(gnt_o), 160'(2'b01));
    step_gnt(1, 1, 2'b01, 108);
    step_gnt(1, 1, 2'b10, 109);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arb_ctrl.md
MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

Interface
REQ-001 SHALL have parameter LS_BURST_MAX, default 2: max consecutive LSU grants while fetch waits.
REQ-002 SHALL have port i_clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port i_reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports i_if_req / i_if_addr, input, 1 / 11: fetch read request and byte address.
REQ-005 SHALL have ports o_if_gnt / o_if_rvalid / o_if_rdata, output, 1 / 1 / 32: fetch grant, read valid, word data.
REQ-006 SHALL have ports i_ls_req / i_ls_we / i_ls_size / i_ls_unsigned, input, 1 / 1 / 2 / 1: LSU request, store, size (00 byte, 01 half, 1x word), zero-extend.
REQ-007 SHALL have ports i_ls_addr / i_ls_wdata, input, 11 / 32: LSU byte address, store data.
REQ-008 SHALL have ports o_ls_gnt / o_ls_rvalid / o_ls_rdata, output, 1 / 1 / 32: LSU grant, load valid, extended load data.
REQ-009 SHALL have ports o_addr_even_1, o_addr_even_2, o_addr_odd_1, o_addr_odd_2, output, 10 each: bank port addresses.
REQ-010 SHALL have ports o_data_even_1, o_data_even_2, o_data_odd_1, o_data_odd_2, output, 8 each: bank write bytes.
REQ-011 SHALL have ports o_we_even_1, o_we_even_2, o_we_odd_1, o_we_odd_2, output, 1 each: bank write enables.
REQ-012 SHALL have ports o_lsu_addr, output, 1, and i_mem_data, input, 32: lane-order select and assembled read word from the banked memory.

Function
REQ-013 SHALL grant at most one requester per cycle; gnt combinational in grant cycle C.
REQ-014 SHALL prioritise LSU over fetch, except fetch SHALL win when LSU-grants-while-fetch-waiting counter equals LS_BURST_MAX.
REQ-015 SHALL clear the counter on fetch grant or any cycle i_if_req=0; saturate at LS_BURST_MAX.
REQ-016 SHALL drive bank addresses in C from granted address A: a=A[10:1]; A[0]=0: even_1=odd_1=a, even_2=odd_2=a+1; A[0]=1: odd_1=a, even_1=a+1, odd_2=a+1, even_2=a+2.
REQ-017 SHALL compute bank indices modulo 1024 (A=2047 word access wraps to index 0/1).
REQ-018 SHALL map access byte k (k=0..3) to lanes: A[0]=0: even_1, odd_1, even_2, odd_2; A[0]=1: odd_1, even_1, odd_2, even_2.
REQ-019 SHALL, for LSU store in C, drive wdata byte k on lane k and assert lane k we only for k < nbytes (1/2/4); all other we=0.
REQ-020 SHALL hold all we=0 when no store granted; fetch never writes.
REQ-021 SHALL register A[0] at grant and drive it on o_lsu_addr in C+1.
REQ-022 SHALL assert exactly one of o_if_rvalid/o_ls_rvalid in C+1 for each granted read (fetch or LSU load); none for stores.
REQ-023 SHALL present o_if_rdata=i_mem_data in C+1; o_ls_rdata = low nbytes of i_mem_data, sign- or zero-extended per registered size/unsigned.
REQ-024 SHALL support back-to-back grants every cycle (fully pipelined, one outstanding read per cycle).
REQ-025 SHALL drive rdata outputs 0 when corresponding rvalid=0.

Reset
REQ-026 SHALL, while i_reset=1, force gnt, rvalid, we, o_lsu_addr, rdata and all bank addresses/data to 0 and clear counter and pipeline registers.
REQ-027 SHALL suppress rvalid in cycle after reset deassertion even if a grant preceded reset (in-flight read dropped).

Verification
REQ-028 Both requesters held every cycle, LS_BURST_MAX=2 -> grant pattern LSU, LSU, IF, LSU, LSU, IF.
REQ-029 LSU sw A=0x005, wdata=0xDDCCBBAA -> odd_1=2 (AA), even_1=3 (BB), odd_2=3 (CC), even_2=4 (DD), all 4 we=1.
REQ-030 LSU sb A=0x006, wdata=0x11223344 -> only o_we_even_1=1, addr 3, data 0x44.
REQ-031 LSU lb A=0x005, i_mem_data=0x000000F0 in C+1 -> o_ls_rdata=0xFFFFFFF0; lbu -> 0x000000F0; o_lsu_addr=1.
REQ-032 LSU lw A=0x7FF -> odd_1=1023, even_1=0, odd_2=0, even_2=1.
REQ-033 Fetch granted, i_reset=1 next cycle -> o_if_rvalid=0 throughout, all outputs 0.
